// File: rtl/afc_nco_divclk_gen_if.sv
// rtl/afc_nco_divclk_gen_if.sv - control-code request/ack handshake bundle for the NCO divided-clock generator
interface afc_nco_divclk_gen_if #(
    parameter int CODE_WIDTH = 8
);
    logic [CODE_WIDTH-1:0] control_code;
    logic                  code_valid;
    logic                  code_ack;

    modport master (
        output control_code,
        output code_valid,
        input  code_ack
    );

    modport slave (
        input  control_code,
        input  code_valid,
        output code_ack
    );
endinterface

// File: rtl/afc_nco_divclk_gen.sv
// rtl/afc_nco_divclk_gen.sv - phase-accumulator NCO with even post-divider; optional AFC_NCO_DITHER_EN LFSR dither
module afc_nco_divclk_gen #(
    parameter int                    CODE_WIDTH = 8,
    parameter int                    ACC_WIDTH  = 24,
    parameter logic [ACC_WIDTH-1:0]  BASE_INC   = 24'h100000,
    parameter logic [ACC_WIDTH-1:0]  STEP_INC   = 24'h001000,
    parameter int                    DIV_N      = 4,
    parameter int                    RESET_CODE = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    afc_nco_divclk_gen_if.slave    code_if,
    input  logic                   afc_status,
    output logic                   divclk,
    output logic                   divclk_rise,
    output logic [CODE_WIDTH-1:0]  applied_code,
    output logic [CODE_WIDTH-1:0]  locked_code
);
    localparam int IW    = ACC_WIDTH + CODE_WIDTH;
    localparam int HALF  = DIV_N / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [IW-1:0]    INC_SAT = IW'(1) << (ACC_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT_DROP} state_t;

    // Saturation keeps at most one carry per two clocks so the divider never misses a tick.
    function automatic logic [ACC_WIDTH-1:0] calc_inc(input logic [CODE_WIDTH-1:0] code,
                                                      input logic dith);
        logic [IW-1:0] raw;
        raw = IW'(BASE_INC) + IW'(code) * IW'(STEP_INC) + IW'(dith);
        if (raw > INC_SAT) raw = INC_SAT;
        return raw[ACC_WIDTH-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d, inc_q, inc_d;
    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  divclk_q, divclk_d, divclk_rise_q, divclk_rise_d;
    logic                  code_ack_q, code_ack_d, status_prev_q, status_prev_d;
    logic [CODE_WIDTH-1:0] applied_code_q, applied_code_d, locked_code_q, locked_code_d;
    logic [ACC_WIDTH:0]    acc_sum;
    logic                  tick, boundary, dith;

`ifdef AFC_NCO_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign dith = lfsr_q[0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign dith = 1'b0;
`endif

    always_comb begin
        acc_d          = acc_q;
        div_cnt_d      = div_cnt_q;
        divclk_d       = divclk_q;
        divclk_rise_d  = 1'b0;
        code_ack_d     = 1'b0;
        state_d        = state_q;
        applied_code_d = applied_code_q;
        locked_code_d  = locked_code_q;
        status_prev_d  = afc_status;
        inc_d          = calc_inc(applied_code_q, dith);
        acc_sum        = {1'b0, acc_q} + {1'b0, inc_q};
        tick           = acc_sum[ACC_WIDTH];

        if (enable) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            if (tick) begin
                if (div_cnt_q == CNT_LAST) begin
                    div_cnt_d     = '0;
                    divclk_d      = ~divclk_q;
                    divclk_rise_d = ~divclk_q;
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
        end else begin
            acc_d     = '0;
            div_cnt_d = '0;
            divclk_d  = 1'b0;
        end

        // Applying on the edge where divclk rises keeps every divclk half-period whole.
        boundary = divclk_rise_d || !enable;

        case (state_q)
            S_IDLE: if (code_if.code_valid) state_d = S_PEND;
            S_PEND: begin
                if (!code_if.code_valid) begin
                    state_d = S_IDLE;
                end else if (boundary) begin
                    applied_code_d = code_if.control_code;
                    code_ack_d     = 1'b1;
                    state_d        = S_WAIT_DROP;
                end
            end
            S_WAIT_DROP: if (!code_if.code_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (afc_status && !status_prev_q) locked_code_d = applied_code_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            inc_q          <= calc_inc(CODE_WIDTH'(RESET_CODE), 1'b0);
            div_cnt_q      <= '0;
            divclk_q       <= 1'b0;
            divclk_rise_q  <= 1'b0;
            code_ack_q     <= 1'b0;
            status_prev_q  <= 1'b0;
            applied_code_q <= CODE_WIDTH'(RESET_CODE);
            locked_code_q  <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            inc_q          <= inc_d;
            div_cnt_q      <= div_cnt_d;
            divclk_q       <= divclk_d;
            divclk_rise_q  <= divclk_rise_d;
            code_ack_q     <= code_ack_d;
            status_prev_q  <= status_prev_d;
            applied_code_q <= applied_code_d;
            locked_code_q  <= locked_code_d;
        end
    end

    assign code_if.code_ack = code_ack_q;
    assign divclk           = divclk_q;
    assign divclk_rise      = divclk_rise_q;
    assign applied_code     = applied_code_q;
    assign locked_code      = locked_code_q;
endmodule
